// File: rtl/pc_stack.sv
// Return-address stack beside pc_gen: CALL pushes pc_i+1, RET pops; brc suppresses both.
// Latency: 1 clock for push/pop. stack_pc is a plain register output.
// Backpressure: none; one operation per clock. Overflow and underflow are flagged sticky.
`ifndef PC_NEXT
`define PC_NEXT 3'd0
`endif
`ifndef PC_SKIP
`define PC_SKIP 3'd1
`endif
`ifndef PC_GOTO
`define PC_GOTO 3'd2
`endif
`ifndef PC_CALL
`define PC_CALL 3'd3
`endif
`ifndef PC_RET
`define PC_RET 3'd4
`endif

module pc_stack #(
    parameter int DEPTH = 2,
    parameter int AW    = 11,
    parameter int CW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    ctl,
    input  logic          brc,
    input  logic [AW-1:0] pc_i,
    input  logic [2:0]    dbg_sel,
    output logic [AW-1:0] stack_pc,
    output logic [AW-1:0] dbg_pc,
    output logic [CW-1:0] depth,
    output logic          ovf,
    output logic          unf
);

    logic [AW-1:0] lvl [DEPTH];
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;

    assign push  = (ctl == `PC_CALL) && !brc;
    assign pop   = (ctl == `PC_RET) && !brc;
    assign full  = (depth == CW'(DEPTH));
    assign empty = (depth == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                lvl[i] <= '0;
            end
            depth <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else if (push) begin
            lvl[0] <= pc_i + AW'(1);
            for (int i = 1; i < DEPTH; i++) begin
                lvl[i] <= lvl[i-1];
            end
            if (full) begin
                ovf <= 1'b1;
            end else begin
                depth <= depth + CW'(1);
            end
        end else if (pop) begin
            // Bottom level keeps its value, so it is duplicated upward.
            for (int i = 0; i < DEPTH - 1; i++) begin
                lvl[i] <= lvl[i+1];
            end
            if (empty) begin
                unf <= 1'b1;
            end else begin
                depth <= depth - CW'(1);
            end
        end
    end

    assign stack_pc = lvl[0];

    always_comb begin
        dbg_pc = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (dbg_sel == 3'(i)) begin
                dbg_pc = lvl[i];
            end
        end
    end

endmodule

// File: doc/pc_stack.md
# pc_stack

Hardware return-address stack feeding the `stack_pc` input of the program-counter generator. On a CALL it pushes the return address (current PC + 1); on a RET it pops, and the popped value is the one already presented to `pc_gen` during the RET cycle. Pushes and pops are suppressed while a skip (`brc`) is in effect, which mirrors `pc_gen` priority. It sits beside `pc_gen` in the fetch stage and is the only writer of `stack_pc`.

## Interface
- `DEPTH`, 2: number of stack levels; legal range 2..8.
- `AW`, 11: PC/address width.
- `CW`, 4: width of `depth` output; must satisfy 2^CW > DEPTH.

- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ctl`  in  3  PC control code, same encoding as `pc_gen`; only `` `PC_CALL `` and `` `PC_RET `` are acted on.
- `brc`  in  1  skip in effect; when 1, `ctl` is ignored this cycle.
- `pc_i`  in  AW  current PC (address of the executing instruction).
- `dbg_sel`  in  3  level index for the debug read port (0 = top).
- `stack_pc`  out  AW  top-of-stack; the RET target.
- `dbg_pc`  out  AW  contents of level `dbg_sel`; 0 if `dbg_sel` ≥ DEPTH.
- `depth`  out  CW  number of valid entries, 0..DEPTH.
- `ovf`  out  1  sticky: a push occurred while full.
- `unf`  out  1  sticky: a pop occurred while empty.

## Operation
- Storage is `lvl[0..DEPTH-1]`, with `lvl[0]` as the top. `stack_pc = lvl[0]`.
- push = (ctl == `` `PC_CALL ``) & ~brc. pop = (ctl == `` `PC_RET ``) & ~brc. `` `PC_GOTO `` and all other codes are no-ops.
- Push: `lvl[0] <= pc_i + 1` (mod 2^AW; 0x7FF+1 → 0x000). Then `lvl[i] <= lvl[i-1]` for i ≥ 1. The bottom entry is discarded.
- Push when `depth == DEPTH`: shift happens anyway and the oldest entry is lost. `depth` stays at DEPTH and `ovf <= 1`.
- Push otherwise: `depth <= depth + 1`.
- Pop: `lvl[i] <= lvl[i+1]` for i < DEPTH-1. `lvl[DEPTH-1]` keeps its value (it is duplicated upward, not zeroed).
- Pop when `depth == 0`: the shift still happens and `depth` stays 0. `unf <= 1`.
- Pop otherwise: `depth <= depth - 1`.
- push and pop are mutually exclusive by decode; no simultaneous case exists.
- `ovf` and `unf` are cleared only by `rst`.
- `dbg_pc` is a combinational mux of `lvl`; it has no side effects.

## Timing
- Reset (async assert): all `lvl` = 0, `depth` = 0, `ovf` = 0, `unf` = 0. So `stack_pc` = 0 and `dbg_pc` = 0.
- Deassertion is sampled at the next `clk` edge; no operation takes effect while `rst` = 1.
- Reset asserted mid-sequence clears state immediately, with no clock needed.
- `stack_pc` is a direct register output. It has zero combinational dependence on `ctl`, `brc` or `pc_i`.
- RET in cycle N: `pc_gen` consumes `stack_pc` (= `lvl[0]`) during cycle N. After edge N, `stack_pc` shows the next entry.
- CALL in cycle N: the new top is visible on `stack_pc` from cycle N+1. Latency is 1 clock.
- `depth`, `ovf` and `unf` update on the same edge as the operation that causes them.
- Back-to-back CALL/RET on consecutive cycles is supported at full rate, one operation per clock.

## Test plan
- Reset, then CALL at pc_i=0x010 → `stack_pc`=0x011 and `depth`=1 next cycle. Then RET → `stack_pc` is 0x011 during the RET cycle; afterwards `depth`=0 and `ovf`=`unf`=0.
- DEPTH=2: CALL at 0x100, CALL at 0x200, CALL at 0x300 → after the third CALL, `lvl`={0x301,0x201}, `depth`=2, `ovf`=1. Then RET, RET → targets 0x301 then 0x201. `depth`=0, `ovf` stays 1.
- From empty after the scenario above, RET → `unf`=1 and `depth` stays 0. `stack_pc` shows the duplicated bottom value (0x201).
- CALL with brc=1 at pc_i=0x050 → no change to `lvl` or `depth`. RET with brc=1 → no change. `ctl`=`` `PC_GOTO `` → no change.
- CALL at pc_i=0x7FF → `stack_pc`=0x000 (wrap).
- After two CALLs, assert `rst` asynchronously between edges → all outputs are 0 immediately. Then `dbg_sel`=0..2 reads 0, 0, 0.
